// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between a set of requesters and the round-robin arbiter.
// The arbiter side uses the slave modport; the requester side uses master.
interface rr_priority_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_WD  = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] o_gnt;
  logic [IDX_WD-1:0]  o_gnt_idx;
  logic               o_gnt_valid;

  modport master (
    output i_req,
    input  o_gnt,
    input  o_gnt_idx,
    input  o_gnt_valid
  );

  modport slave (
    input  i_req,
    output o_gnt,
    output o_gnt_idx,
    output o_gnt_valid
  );
endinterface

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with leading-one (highest index first) selection.
// A rotating mask drops the last winner to lowest priority; each grant is
// held until its requester drops or MAX_HOLD cycles elapse, then the next
// winner is loaded with no idle gap. All outputs are registered.
module rr_priority_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_WD   = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 4,
  parameter int HOLD_WD  = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_priority_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic logic [IDX_WD-1:0] lead_one(input logic [NUM_REQ-1:0] vec);
    logic [IDX_WD-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (vec[k]) begin
        idx = IDX_WD'(k);
      end
    end
    return idx;
  endfunction

  // Bits strictly below the last winner: (1 << last) - 1.
  function automatic logic [NUM_REQ-1:0] below_mask(input logic [IDX_WD-1:0] last);
    logic [NUM_REQ-1:0] m;
    for (int k = 0; k < NUM_REQ; k++) begin
      m[k] = (IDX_WD'(k) < last);
    end
    return m;
  endfunction

  // One-hot decode of a grant index.
  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_WD-1:0] idx);
    logic [NUM_REQ-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [NUM_REQ-1:0] gnt_r;
  logic [IDX_WD-1:0]  idx_r;
  logic               valid_r;
  logic [HOLD_WD-1:0] hold_r;
  logic [IDX_WD-1:0]  last_r;

  logic [NUM_REQ-1:0] gnt_nxt_s;
  logic [IDX_WD-1:0]  idx_nxt_s;
  logic               valid_nxt_s;
  logic [HOLD_WD-1:0] hold_nxt_s;
  logic [IDX_WD-1:0]  last_nxt_s;

  logic [NUM_REQ-1:0] masked_s;
  logic [IDX_WD-1:0]  winner_s;
  logic               req_any_s;
  logic               release_s;

  // Winner search: masked leading one first, fall back to the full vector.
  always_comb begin
    req_any_s = |bus.i_req;
    masked_s  = bus.i_req & below_mask(last_r);
    if (masked_s != {NUM_REQ{1'b0}}) begin
      winner_s = lead_one(masked_s);
    end else begin
      winner_s = lead_one(bus.i_req);
    end
    if (state_r == ST_GRANT) begin
      release_s = (bus.i_req[idx_r] == 1'b0) ||
                  (hold_r == HOLD_WD'(MAX_HOLD - 1));
    end else begin
      release_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: stay in GRANT while any request remains at release.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s && !req_any_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered grant, hold counter and rotation pointer.
  always_comb begin
    gnt_nxt_s   = gnt_r;
    idx_nxt_s   = idx_r;
    valid_nxt_s = valid_r;
    hold_nxt_s  = hold_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE, ST_GRANT: begin
        if ((state_r == ST_GRANT) && !release_s) begin
          hold_nxt_s = hold_r + HOLD_WD'(1);
        end else if (req_any_s) begin
          gnt_nxt_s   = one_hot(winner_s);
          idx_nxt_s   = winner_s;
          valid_nxt_s = 1'b1;
          hold_nxt_s  = {HOLD_WD{1'b0}};
          last_nxt_s  = winner_s;
        end else begin
          gnt_nxt_s   = {NUM_REQ{1'b0}};
          idx_nxt_s   = {IDX_WD{1'b0}};
          valid_nxt_s = 1'b0;
          hold_nxt_s  = {HOLD_WD{1'b0}};
        end
      end
      default: begin
        gnt_nxt_s   = {NUM_REQ{1'b0}};
        idx_nxt_s   = {IDX_WD{1'b0}};
        valid_nxt_s = 1'b0;
        hold_nxt_s  = {HOLD_WD{1'b0}};
        last_nxt_s  = {IDX_WD{1'b0}};
      end
    endcase
  end

  // Grant datapath registers; reset overrides any grant in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_r   <= {NUM_REQ{1'b0}};
      idx_r   <= {IDX_WD{1'b0}};
      valid_r <= 1'b0;
      hold_r  <= {HOLD_WD{1'b0}};
      last_r  <= {IDX_WD{1'b0}};
    end else begin
      gnt_r   <= gnt_nxt_s;
      idx_r   <= idx_nxt_s;
      valid_r <= valid_nxt_s;
      hold_r  <= hold_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  assign bus.o_gnt       = gnt_r;
  assign bus.o_gnt_idx   = idx_r;
  assign bus.o_gnt_valid = valid_r;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed testbench for rr_priority_arbiter (NUM_REQ=8, MAX_HOLD=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rr_priority_arbiter;

  localparam int NUM_REQ  = 8;
  localparam int IDX_WD   = 3;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  rr_priority_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_WD(IDX_WD)) bus ();

  rr_priority_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_WD  (IDX_WD),
    .MAX_HOLD(MAX_HOLD),
    .HOLD_WD (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the values differ.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check the full grant triple against an expected index/valid pair.
  task automatic check_gnt(input string tag, input int exp_idx, input logic exp_valid);
    logic [7:0] one;
    logic [7:0] exp_gnt;
    one = 8'd1;
    exp_gnt = exp_valid ? (one << exp_idx) : 8'd0;
    check_val({tag, ".gnt"},   32'(bus.o_gnt),       32'(exp_gnt));
    check_val({tag, ".idx"},   32'(bus.o_gnt_idx),   exp_valid ? 32'(exp_idx) : 32'd0);
    check_val({tag, ".valid"}, 32'(bus.o_gnt_valid), 32'(exp_valid));
  endtask

  // Reset for two cycles, then release with req0 applied as cycle 0.
  task automatic do_reset(input logic [7:0] req0);
    @(negedge clk);
    reset = 1'b1;
    bus.i_req = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.i_req = req0;
  endtask

  int two_way [12] = '{7, 7, 7, 7, 2, 2, 2, 2, 7, 7, 7, 7};
  int no_pre  [9]  = '{0, 0, 0, 0, 7, 7, 7, 7, 0};
  int mid_rst [9]  = '{5, 5, 5, 5, 0, 0, 0, 0, 5};

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.i_req = 8'hFF;

    // Reset held three cycles with all requests high.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_gnt("reset_hold", 0, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_gnt("reset_first", 7, 1'b1);

    // Two-way rotation between 7 and 2.
    do_reset(8'h84);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_gnt($sformatf("two_way_c%0d", c), two_way[c-1], 1'b1);
    end

    // Lone requester keeps its grant across hold expiries.
    do_reset(8'h08);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_gnt($sformatf("lone_c%0d", c), 3, 1'b1);
    end

    // Early release back to idle.
    do_reset(8'h02);
    @(negedge clk);
    check_gnt("early_c1", 1, 1'b1);
    @(negedge clk);
    check_gnt("early_c2", 1, 1'b1);
    bus.i_req = 8'h00;
    @(negedge clk);
    check_gnt("early_c3", 0, 1'b0);
    @(negedge clk);
    check_gnt("early_c4", 0, 1'b0);

    // Full load: descending order, four cycles each, then wrap.
    do_reset(8'hFF);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check_gnt($sformatf("full_c%0d", c), (7 - (c - 1) / 4) & 7, 1'b1);
      check_val($sformatf("full_onehot_c%0d", c), 32'($onehot0(bus.o_gnt)), 32'd1);
    end

    // No preemption: a higher request arriving mid-grant waits.
    do_reset(8'h01);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check_gnt($sformatf("nopre_c%0d", c), no_pre[c-1], 1'b1);
      bus.i_req = 8'h81;
    end

    // Reset mid-grant on the second hold cycle of idx 5.
    do_reset(8'h21);
    @(negedge clk);
    check_gnt("midrst_c1", 5, 1'b1);
    @(negedge clk);
    check_gnt("midrst_c2", 5, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_gnt("midrst_c3", 0, 1'b0);
    reset = 1'b0;
    for (int c = 4; c <= 12; c++) begin
      @(negedge clk);
      check_gnt($sformatf("midrst_c%0d", c), mid_rst[c-4], 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
